// File: rtl/dcmac_rx_pkg.sv
// dcmac_rx_pkg: shared widths, tuser bit positions and ingress FSM states for the DCMAC RX segment-to-AXIS path.
package dcmac_rx_pkg;
    localparam int SEG_W     = 128;
    localparam int OUT_W     = 512;
    localparam int KEEP_W    = OUT_W / 8;
    localparam int FIFO_W    = OUT_W + KEEP_W + 2;
    localparam int TUSER_ERR = 0;
    localparam int TUSER_SOP = 1;
    localparam int TUSER_ENA = 2;

    typedef enum logic [1:0] {IDLE, IN_PKT, DROP} rx_state_t;

    function automatic logic [15:0] mty_keep(input logic [3:0] mty);
        return 16'hFFFF >> mty;
    endfunction
endpackage

// File: rtl/dcmac_rx_sync_fifo.sv
// dcmac_rx_sync_fifo: synchronous FIFO with a registered output stage; free counts every held entry, including the output register.
module dcmac_rx_sync_fifo #(
    parameter int WIDTH = 578,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [$clog2(DEPTH):0]   free,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count;
    logic pop, push, load;

    assign pop  = rd_valid && rd_ready;
    assign push = wr_en && (count != (AW+1)'(DEPTH) || pop);
    assign load = (wr_ptr != rd_ptr) && (!rd_valid || rd_ready);
    assign free = (AW+1)'(DEPTH) - count;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (load) begin
                rd_data  <= mem[rd_ptr[AW-1:0]];
                rd_ptr   <= rd_ptr + 1'b1;
                rd_valid <= 1'b1;
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/dcmac_rx_seg_to_axis.sv
// dcmac_rx_seg_to_axis: packs deskewed DCMAC RX segments into 512-bit AXI-Stream beats,
// truncating or aborting packets so the output FIFO never overflows.
module dcmac_rx_seg_to_axis
    import dcmac_rx_pkg::*;
#(
    parameter int SEG_COUNT  = 2,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [SEG_W-1:0]  in0_tdata,
    input  logic [3:0]        in0_tid,
    input  logic [2:0]        in0_tuser,
    input  logic              in0_tlast,
    input  logic              in0_tvalid,
    input  logic [SEG_W-1:0]  in1_tdata,
    input  logic [3:0]        in1_tid,
    input  logic [2:0]        in1_tuser,
    input  logic              in1_tlast,
    input  logic              in1_tvalid,
    input  logic [SEG_W-1:0]  in2_tdata,
    input  logic [3:0]        in2_tid,
    input  logic [2:0]        in2_tuser,
    input  logic              in2_tlast,
    input  logic              in2_tvalid,
    input  logic [SEG_W-1:0]  in3_tdata,
    input  logic [3:0]        in3_tid,
    input  logic [2:0]        in3_tuser,
    input  logic              in3_tlast,
    input  logic              in3_tvalid,
    output logic [OUT_W-1:0]  m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [31:0]       pkt_count,
    output logic [31:0]       err_count,
    output logic [31:0]       drop_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [SEG_W-1:0] seg_data [4];
    logic [3:0]       seg_mty  [4];
    logic [2:0]       seg_user [4];
    logic [3:0]       seg_last;

    assign seg_data = '{in0_tdata, in1_tdata, in2_tdata, in3_tdata};
    assign seg_mty  = '{in0_tid, in1_tid, in2_tid, in3_tid};
    assign seg_user = '{in0_tuser, in1_tuser, in2_tuser, in3_tuser};
    assign seg_last = {in3_tlast, in2_tlast, in1_tlast, in0_tlast};

    logic [OUT_W-1:0]  b_data;
    logic [KEEP_W-1:0] b_keep;
    logic b_last, b_err, b_sop, seen;

    // Segments after the first tlast carry nothing; their SOP/ERR are ignored too.
    always_comb begin
        b_data = '0;
        b_keep = '0;
        b_last = 1'b0;
        b_err  = 1'b0;
        b_sop  = 1'b0;
        seen   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k < SEG_COUNT) begin
                b_data[k*SEG_W +: SEG_W] = seg_data[k];
                if (seg_user[k][TUSER_ENA]) begin
                    b_keep[k*16 +: 16] = seen ? 16'h0 : seg_last[k] ? mty_keep(seg_mty[k]) : 16'hFFFF;
                    b_sop  = b_sop | (!seen && seg_user[k][TUSER_SOP]);
                    b_err  = b_err | (!seen && seg_last[k] && seg_user[k][TUSER_ERR]);
                    b_last = b_last | seg_last[k];
                    seen   = seen | seg_last[k];
                end
            end
        end
    end

    logic [OUT_W-1:0]  ing_data;
    logic [KEEP_W-1:0] ing_keep;
    logic ing_valid, ing_last, ing_err, ing_sop;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ing_valid <= 1'b0;
            ing_data  <= '0;
            ing_keep  <= '0;
            ing_last  <= 1'b0;
            ing_err   <= 1'b0;
            ing_sop   <= 1'b0;
        end else begin
            ing_valid <= in0_tvalid;
            ing_data  <= b_data;
            ing_keep  <= b_keep;
            ing_last  <= b_last;
            ing_err   <= b_err;
            ing_sop   <= b_sop;
        end
    end

    rx_state_t state, state_nx;
    logic [CW-1:0] free;
    logic wr_en, wr_abort, drop;

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Packets are only started with two free entries, leaving room for a terminator beat.
    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        wr_abort = 1'b0;
        drop     = 1'b0;
        if (ing_valid) begin
            case (state)
                IDLE: begin
                    wr_en    = ing_sop && free >= CW'(2);
                    drop     = !wr_en;
                    state_nx = ing_last ? IDLE : wr_en ? IN_PKT : DROP;
                end
                IN_PKT: begin
                    wr_en    = 1'b1;
                    wr_abort = ing_sop || (!ing_last && free < CW'(2));
                    drop     = wr_abort;
                    state_nx = ing_last ? IDLE : wr_abort ? DROP : IN_PKT;
                end
                default: state_nx = ing_last ? IDLE : DROP;
            endcase
        end
    end

    logic [FIFO_W-1:0] rd_data;

    dcmac_rx_sync_fifo #(.WIDTH(FIFO_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .wr_data  ({ing_data, ing_keep, ing_last | wr_abort, ing_err | wr_abort}),
        .free     (free),
        .rd_data  (rd_data),
        .rd_valid (m_axis_tvalid),
        .rd_ready (m_axis_tready)
    );

    assign m_axis_tdata = rd_data[FIFO_W-1 -: OUT_W];
    assign m_axis_tkeep = rd_data[KEEP_W+1:2];
    assign m_axis_tlast = rd_data[1];
    assign m_axis_tuser = rd_data[0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pkt_count  <= '0;
            err_count  <= '0;
            drop_count <= '0;
        end else begin
            drop_count <= drop_count + 32'(drop);
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                pkt_count <= pkt_count + 1'b1;
                err_count <= err_count + 32'(m_axis_tuser);
            end
        end
    end
endmodule

// File: tb/tb_dcmac_rx_seg_to_axis.sv
// tb_dcmac_rx_seg_to_axis: table-driven single-beat vectors plus directed multi-beat sequences
// for truncation, abort, stray beats, latency and mid-stream reset.
module tb_dcmac_rx_seg_to_axis;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [127:0] in0_tdata = '0, in1_tdata = '0, in2_tdata = '0, in3_tdata = '0;
    logic [3:0] in0_tid = '0, in1_tid = '0, in2_tid = '0, in3_tid = '0;
    logic [2:0] in0_tuser = '0, in1_tuser = '0, in2_tuser = '0, in3_tuser = '0;
    logic in0_tlast = 0, in1_tlast = 0, in2_tlast = 0, in3_tlast = 0;
    logic in0_tvalid = 0, in1_tvalid = 0, in2_tvalid = 0, in3_tvalid = 0;
    logic [511:0] m_axis_tdata;
    logic [63:0] m_axis_tkeep;
    logic m_axis_tlast, m_axis_tuser, m_axis_tvalid;
    logic m_axis_tready = 1'b1;
    logic [31:0] pkt_count, err_count, drop_count;

    always #5 clk = ~clk;

    dcmac_rx_seg_to_axis #(.SEG_COUNT(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .in0_tdata(in0_tdata), .in0_tid(in0_tid), .in0_tuser(in0_tuser), .in0_tlast(in0_tlast), .in0_tvalid(in0_tvalid),
        .in1_tdata(in1_tdata), .in1_tid(in1_tid), .in1_tuser(in1_tuser), .in1_tlast(in1_tlast), .in1_tvalid(in1_tvalid),
        .in2_tdata(in2_tdata), .in2_tid(in2_tid), .in2_tuser(in2_tuser), .in2_tlast(in2_tlast), .in2_tvalid(in2_tvalid),
        .in3_tdata(in3_tdata), .in3_tid(in3_tid), .in3_tuser(in3_tuser), .in3_tlast(in3_tlast), .in3_tvalid(in3_tvalid),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .pkt_count(pkt_count), .err_count(err_count), .drop_count(drop_count)
    );

    localparam logic [2:0] N = 3'b000, E = 3'b100, ES = 3'b110, EE = 3'b101, ESE = 3'b111;
    localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [3:0][2:0] u;
        logic [3:0]      l;
        logic [3:0][3:0] m;
        logic [7:0]      s;
        logic [63:0]     keep;
        logic            last;
        logic            user;
    } vec_t;

    typedef struct {
        logic [63:0] keep;
        logic        last;
        logic        user;
        logic [7:0]  b0;
        logic [7:0]  b3;
    } cap_t;

    cap_t q[$];
    int vecs = 0;
    int errs = 0;

    always @(negedge clk)
        if (resetn && m_axis_tvalid && m_axis_tready)
            q.push_back('{m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tdata[7:0], m_axis_tdata[511:504]});

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkq(input string nm, input int i, input logic [63:0] keep, input logic last,
                        input logic user, input logic [7:0] b0);
        if (i >= q.size()) begin
            cmp({nm, " present"}, 64'(q.size()), 64'(i + 1));
            return;
        end
        cmp({nm, " keep"}, q[i].keep, keep);
        cmp({nm, " last"}, 64'(q[i].last), 64'(last));
        cmp({nm, " user"}, 64'(q[i].user), 64'(user));
        cmp({nm, " byte0"}, 64'(q[i].b0), 64'(b0));
    endtask

    task automatic chk_cnt(input string nm, input int p, input int e, input int d);
        cmp({nm, " pkt_count"}, 64'(pkt_count), 64'(p));
        cmp({nm, " err_count"}, 64'(err_count), 64'(e));
        cmp({nm, " drop_count"}, 64'(drop_count), 64'(d));
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0][2:0] u, input logic [3:0] l, input logic [3:0][3:0] m, input logic [7:0] s);
        @(posedge clk);
        #1;
        in0_tdata = {16{s}};
        in1_tdata = {16{s + 8'd1}};
        in2_tdata = {16{s + 8'd2}};
        in3_tdata = {16{s + 8'd3}};
        {in3_tuser, in2_tuser, in1_tuser, in0_tuser} = u;
        {in3_tlast, in2_tlast, in1_tlast, in0_tlast} = l;
        {in3_tid, in2_tid, in1_tid, in0_tid} = m;
        {in3_tvalid, in2_tvalid, in1_tvalid, in0_tvalid} = 4'hF;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        {in3_tvalid, in2_tvalid, in1_tvalid, in0_tvalid} = 4'h0;
        {in3_tuser, in2_tuser, in1_tuser, in0_tuser} = '0;
        {in3_tlast, in2_tlast, in1_tlast, in0_tlast} = '0;
    endtask

    task automatic pkt1(input logic [7:0] s);
        beat({E, E, E, ES}, 4'b1000, '0, s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        vec_t tv[8];
        tv[0] = '{{E, E, E, ESE}, 4'b0001, '0, 8'h10, 64'h0000_0000_0000_FFFF, 1'b1, 1'b1};
        tv[1] = '{{E, E, E, ES}, 4'b1000, '0, 8'h11, ALL, 1'b1, 1'b0};
        tv[2] = '{{E, E, E, ES}, 4'b0100, {4'd0, 4'd15, 4'd0, 4'd0}, 8'h12, 64'h0000_0001_FFFF_FFFF, 1'b1, 1'b0};
        tv[3] = '{{E, E, EE, ES}, 4'b0010, {4'd0, 4'd0, 4'd8, 4'd0}, 8'h13, 64'h0000_0000_00FF_FFFF, 1'b1, 1'b1};
        tv[4] = '{{EE, E, E, ES}, 4'b0010, {4'd0, 4'd0, 4'd2, 4'd0}, 8'h14, 64'h0000_0000_3FFF_FFFF, 1'b1, 1'b0};
        tv[5] = '{{E, E, EE, ES}, 4'b0011, {4'd0, 4'd0, 4'd0, 4'd1}, 8'h15, 64'h0000_0000_0000_7FFF, 1'b1, 1'b0};
        tv[6] = '{{N, E, N, ES}, 4'b0100, '0, 8'h16, 64'h0000_FFFF_0000_FFFF, 1'b1, 1'b0};
        tv[7] = '{{EE, E, E, ES}, 4'b1000, {4'd4, 4'd0, 4'd0, 4'd0}, 8'h17, 64'h0FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

        wait_cyc(3);
        resetn = 1'b1;
        cmp("reset tvalid", 64'(m_axis_tvalid), 64'd0);
        cmp("reset tdata", m_axis_tdata[63:0], 64'd0);
        chk_cnt("reset", 0, 0, 0);

        // Latency: sampled at edge 0, not visible after edge 1, visible after edge 2.
        pkt1(8'h01);
        idle();
        wait_cyc(1);
        cmp("latency edge1 tvalid", 64'(m_axis_tvalid), 64'd0);
        wait_cyc(1);
        cmp("latency edge2 tvalid", 64'(m_axis_tvalid), 64'd1);
        wait_cyc(3);
        q.delete();

        for (int i = 0; i < 8; i++) begin
            beat(tv[i].u, tv[i].l, tv[i].m, tv[i].s);
            idle();
            wait_cyc(4);
            cmp($sformatf("vec%0d count", i), 64'(q.size()), 64'd1);
            chkq($sformatf("vec%0d", i), 0, tv[i].keep, tv[i].last, tv[i].user, tv[i].s);
            if (q.size() > 0)
                cmp($sformatf("vec%0d byte63", i), 64'(q[0].b3), 64'(tv[i].s + 8'd3));
            q.delete();
        end
        chk_cnt("table", 9, 3, 0);

        // Three-beat packet ending on seg1 with MTY=4.
        beat({E, E, E, ES}, 4'b0000, '0, 8'h20);
        beat({E, E, E, E}, 4'b0000, '0, 8'h21);
        beat({E, E, E, E}, 4'b0010, {4'd0, 4'd0, 4'd4, 4'd0}, 8'h22);
        idle();
        wait_cyc(6);
        cmp("3beat count", 64'(q.size()), 64'd3);
        chkq("3beat b0", 0, ALL, 1'b0, 1'b0, 8'h20);
        chkq("3beat b1", 1, ALL, 1'b0, 1'b0, 8'h21);
        chkq("3beat b2", 2, 64'h0000_0000_0FFF_FFFF, 1'b1, 1'b0, 8'h22);
        chk_cnt("3beat", 10, 3, 0);
        q.delete();

        // Stalled sink: 10-beat packet truncated at the 4th beat.
        m_axis_tready = 1'b0;
        beat({E, E, E, ES}, 4'b0000, '0, 8'h30);
        for (int i = 1; i < 9; i++)
            beat({E, E, E, E}, 4'b0000, '0, 8'(8'h30 + i));
        beat({E, E, E, E}, 4'b0001, '0, 8'h39);
        idle();
        wait_cyc(4);
        cmp("trunc held tvalid", 64'(m_axis_tvalid), 64'd1);
        cmp("trunc held byte0", 64'(m_axis_tdata[7:0]), 64'h30);
        cmp("trunc drop_count", 64'(drop_count), 64'd1);
        wait_cyc(3);
        cmp("trunc still byte0", 64'(m_axis_tdata[7:0]), 64'h30);
        m_axis_tready = 1'b1;
        wait_cyc(8);
        cmp("trunc count", 64'(q.size()), 64'd4);
        chkq("trunc b0", 0, ALL, 1'b0, 1'b0, 8'h30);
        chkq("trunc b2", 2, ALL, 1'b0, 1'b0, 8'h32);
        chkq("trunc b3", 3, ALL, 1'b1, 1'b1, 8'h33);
        chk_cnt("trunc", 11, 4, 1);
        q.delete();

        // Stray non-SOP beat in IDLE, then a clean 2-beat packet.
        beat({E, E, E, E}, 4'b0001, '0, 8'h40);
        beat({E, E, E, ES}, 4'b0000, '0, 8'h41);
        beat({E, E, E, E}, 4'b1000, '0, 8'h42);
        idle();
        wait_cyc(6);
        cmp("stray count", 64'(q.size()), 64'd2);
        chkq("stray b0", 0, ALL, 1'b0, 1'b0, 8'h41);
        chkq("stray b1", 1, ALL, 1'b1, 1'b0, 8'h42);
        chk_cnt("stray", 12, 4, 2);
        q.delete();

        // SOP mid-packet: terminator, new packet dropped through EOP, then recovery.
        beat({E, E, E, ES}, 4'b0000, '0, 8'h50);
        beat({E, E, E, E}, 4'b0000, '0, 8'h51);
        beat({E, E, E, ES}, 4'b0000, '0, 8'h52);
        beat({E, E, E, E}, 4'b0000, '0, 8'h53);
        beat({E, E, E, E}, 4'b0001, '0, 8'h54);
        pkt1(8'h55);
        idle();
        wait_cyc(6);
        cmp("abort count", 64'(q.size()), 64'd4);
        chkq("abort b1", 1, ALL, 1'b0, 1'b0, 8'h51);
        chkq("abort term", 2, ALL, 1'b1, 1'b1, 8'h52);
        chkq("abort next", 3, ALL, 1'b1, 1'b0, 8'h55);
        chk_cnt("abort", 14, 5, 3);
        q.delete();

        // Reset with a partial packet buffered.
        m_axis_tready = 1'b0;
        beat({E, E, E, ES}, 4'b0000, '0, 8'h60);
        beat({E, E, E, E}, 4'b0000, '0, 8'h61);
        beat({E, E, E, E}, 4'b0000, '0, 8'h62);
        idle();
        wait_cyc(4);
        cmp("prereset tvalid", 64'(m_axis_tvalid), 64'd1);
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        cmp("midreset tvalid", 64'(m_axis_tvalid), 64'd0);
        chk_cnt("midreset", 0, 0, 0);
        m_axis_tready = 1'b1;
        beat({E, E, E, E}, 4'b0001, '0, 8'h63);
        idle();
        wait_cyc(6);
        cmp("postreset stale", 64'(q.size()), 64'd0);
        cmp("postreset drop", 64'(drop_count), 64'd1);
        pkt1(8'h64);
        idle();
        wait_cyc(6);
        cmp("postreset count", 64'(q.size()), 64'd1);
        chkq("postreset pkt", 0, ALL, 1'b1, 1'b0, 8'h64);
        chk_cnt("postreset", 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/dcmac_rx_seg_to_axis.md
DCMAC_RX_SEG_TO_AXIS -- requirements
Module: dcmac_rx_seg_to_axis

Interface
REQ-001 Parameter SEG_COUNT, default 2, segments per beat carried by the upstream deskew stage; only 2 and 4 are legal.
REQ-002 Parameter FIFO_DEPTH, default 32, output FIFO depth in beats; power of two, at least 4.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 in0..in3_tdata  input  128 each  segment payload; byte 0 in bits [7:0].
REQ-006 in0..in3_tid  input  4 each  MTY: empty byte count, meaningful only on the tlast segment.
REQ-007 in0..in3_tuser  input  3 each  bit0 ERR (FCS error, valid on EOP), bit1 SOP, bit2 ENA.
REQ-008 in0..in3_tlast  input  1 each  end-of-packet segment.
REQ-009 in0..in3_tvalid  input  1 each  beat valid; all equal; no tready, so input cannot be stalled.
REQ-010 m_axis_tdata  output  512  packed beat; segment k occupies bits [128k+127:128k].
REQ-011 m_axis_tkeep  output  64  byte enables.
REQ-012 m_axis_tlast / m_axis_tuser  output  1 / 1  end of packet / packet bad (FCS error, truncated or aborted).
REQ-013 m_axis_tvalid  output  1 / m_axis_tready  input  1  standard AXI-Stream handshake.
REQ-014 pkt_count, err_count, drop_count  output  32 each  statistics; wrap on overflow.

Function
REQ-015 A beat SHALL be accepted when in0_tvalid=1; in2/in3 SHALL be ignored when SEG_COUNT=2, and out bits [511:256] SHALL then be 0.
REQ-016 Per segment k: tkeep[16k+15:16k] = 16'hFFFF if ENA and not tlast; low (16-MTY) bits set if ENA and tlast; 0 if ENA=0 or k is above the first tlast segment.
REQ-017 Beat tlast SHALL be the OR of segment tlast over ENA segments; beat err SHALL be the OR of ERR on the tlast segment.
REQ-018 The ingress FSM SHALL have states IDLE, IN_PKT and DROP.
REQ-019 IDLE, SOP beat with free entries at least 2: write the beat; go to IN_PKT, or stay IDLE if tlast.
REQ-020 IDLE, SOP beat with free entries at most 1: no write; drop_count+1; go to DROP, or stay IDLE if tlast.
REQ-021 IDLE, non-SOP beat: discard; drop_count+1; go to DROP, or stay IDLE if tlast.
REQ-022 IN_PKT, non-SOP beat with free entries at least 2: write unchanged; go to IDLE on tlast.
REQ-023 IN_PKT, non-SOP non-tlast beat with free entries exactly 1: write with tlast=1 and err=1 (truncate); drop_count+1; go to DROP.
REQ-024 IN_PKT, SOP beat: write it as an abort terminator with tlast=1, err=1, and tkeep as computed; drop_count+1; go to DROP, or IDLE if the beat has tlast.
REQ-025 DROP: discard every beat; go to IDLE on a tlast beat.
REQ-026 Invariant: in IN_PKT the FIFO SHALL always hold at least 1 free entry, so the terminator write never overflows.
REQ-027 Latency: with the FIFO empty and m_axis_tready=1, m_axis_tvalid SHALL assert 2 cycles after the edge that samples the input beat (ingress register plus FIFO).
REQ-028 Once asserted, m_axis_tvalid and payload SHALL hold until handshake; a FIFO write and read in the same cycle SHALL both succeed when full.
REQ-029 Counters SHALL increment on output handshake with tlast: pkt_count always, err_count when m_axis_tuser=1.

Reset
REQ-030 While resetn=0 at an edge: FSM to IDLE, FIFO emptied, ingress register cleared, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast/tuser=0, all counters 0.
REQ-031 A packet partly in the FIFO at reset SHALL be discarded; input beats after reset release SHALL be treated as starting in IDLE.

Structure
REQ-032 Shared package dcmac_rx_pkg SHALL hold SEG_W=128, OUT_W=512, and TUSER_ERR=0, TUSER_SOP=1, TUSER_ENA=2.
REQ-033 The FIFO SHALL be sub-module dcmac_rx_sync_fifo (width 578: data, keep, last, err), exposing a free-entry count.

Verification
REQ-034 SEG_COUNT=4, 3-beat packet, last beat tlast on seg1 with MTY=4, tready=1 -> 3 output beats; last tkeep = 64'h0000_0000_0FFF_FFFF; pkt_count=1.
REQ-035 SOP+EOP single beat, seg0 ERR=1, MTY=0 -> one beat, tkeep=64'hFFFF, tlast=1, tuser=1; err_count=1.
REQ-036 FIFO_DEPTH=4, tready=0, 10-beat packet -> 4 beats stored, 4th with tlast=1 and tuser=1; drop_count=1; after tready=1, exactly 4 beats out.
REQ-037 Beat without SOP while IDLE, then valid 2-beat packet -> first beat discarded, drop_count=1; packet delivered intact.
REQ-038 SOP beat arrives mid-packet -> terminator beat with tlast=1 and tuser=1; the new packet is dropped through its EOP.
REQ-039 resetn low for 1 cycle with a packet mid-stream and 3 beats buffered -> m_axis_tvalid=0 next cycle, counters 0, no stale beats emitted.
